// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium core arbiter: FSM states and default widths.
// Latency: n/a. Backpressure: n/a.
package trivium_pkg;
    localparam int DEF_KEY_W = 80;
    localparam int DEF_IV_W  = 80;
    localparam int DEF_OUT_W = 4096;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        KEY  = 3'd2,
        DATA = 3'd3,
        RUN  = 3'd4,
        RESP = 3'd5,
        ERR  = 3'd6
    } state_t;
endpackage

// File: rtl/trivium_core_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: combinational. Backpressure: none, caller decides when to use the grant.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from the farthest offset back toward ptr so the nearest request wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/trivium_core_arbiter.sv
// Shares one Trivium keystream core among N_REQ requesters with a key cache and watchdog.
// Latency: req_rdy at T, core_Drdy from T+1 on a key-cache hit; response after core finishes.
// Backpressure: single outstanding request; rsp_vld held until rsp_rdy, no accept meanwhile.
module trivium_core_arbiter
    import trivium_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int IV_W    = DEF_IV_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int TIMEOUT = 8192
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*KEY_W-1:0] req_key,
    input  logic [N_REQ*IV_W-1:0]  req_iv,
    output logic [N_REQ-1:0]       req_rdy,
    output logic [N_REQ-1:0]       rsp_vld,
    input  logic [N_REQ-1:0]       rsp_rdy,
    output logic [OUT_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [KEY_W-1:0]       core_Kin,
    output logic [IV_W-1:0]        core_Din,
    output logic                   core_Krdy,
    output logic                   core_Drdy,
    output logic                   core_EncDec,
    output logic                   core_EN,
    input  logic [OUT_W-1:0]       core_Dout,
    input  logic                   core_BSY,
    input  logic                   core_Kvld,
    input  logic                   core_Dvld
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant;
    logic [KEY_W-1:0]   cache_key;
    logic               cache_vld;
    logic [WD_W-1:0]    wdog;

    logic [N_REQ-1:0]   gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [KEY_W-1:0]   sel_key;
    logic [IV_W-1:0]    sel_iv;
    logic [N_REQ-1:0]   grant_oh;
    logic               wd_abort;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (req_vld),
        .ptr (ptr),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign sel_key     = req_key[int'(gnt_idx)*KEY_W +: KEY_W];
    assign sel_iv      = req_iv[int'(gnt_idx)*IV_W +: IV_W];
    assign grant_oh    = N_REQ'(1) << grant;
    assign core_EncDec = 1'b0;
    assign wd_abort    = (state == KEY || state == DATA || state == RUN) &&
                         (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= INIT;
            ptr       <= '0;
            grant     <= '0;
            cache_key <= '0;
            cache_vld <= 1'b0;
            wdog      <= '0;
            req_rdy   <= '0;
            rsp_vld   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            core_Kin  <= '0;
            core_Din  <= '0;
            core_Krdy <= 1'b0;
            core_Drdy <= 1'b0;
            core_EN   <= 1'b0;
        end else begin
            req_rdy <= '0;
            if (wd_abort) begin
                // Hung core: drop handshakes, pulse the enable low and forget the key.
                core_Krdy <= 1'b0;
                core_Drdy <= 1'b0;
                core_EN   <= 1'b0;
                cache_vld <= 1'b0;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                state     <= ERR;
            end else begin
                case (state)
                    INIT: begin
                        core_EN <= 1'b1;
                        state   <= IDLE;
                    end
                    IDLE: begin
                        if (gnt_any) begin
                            req_rdy  <= gnt_oh;
                            grant    <= gnt_idx;
                            core_Kin <= sel_key;
                            core_Din <= sel_iv;
                            ptr      <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                            wdog     <= '0;
                            state    <= (cache_vld && sel_key == cache_key) ? DATA : KEY;
                        end
                    end
                    KEY: begin
                        if (core_Krdy && core_Kvld) begin
                            core_Krdy <= 1'b0;
                            cache_key <= core_Kin;
                            cache_vld <= 1'b1;
                            wdog      <= '0;
                            state     <= DATA;
                        end else begin
                            core_Krdy <= 1'b1;
                            wdog      <= wdog + WD_W'(1);
                        end
                    end
                    DATA: begin
                        if (core_Drdy && core_BSY) begin
                            core_Drdy <= 1'b0;
                            wdog      <= '0;
                            state     <= RUN;
                        end else begin
                            core_Drdy <= 1'b1;
                            wdog      <= wdog + WD_W'(1);
                        end
                    end
                    RUN: begin
                        if (!core_BSY && core_Dvld) begin
                            rsp_data <= core_Dout;
                            rsp_err  <= 1'b0;
                            rsp_vld  <= grant_oh;
                            state    <= RESP;
                        end else begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                    RESP: begin
                        if (rsp_rdy[grant]) begin
                            rsp_vld <= '0;
                            rsp_err <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    ERR: begin
                        core_EN <= 1'b1;
                        rsp_vld <= grant_oh;
                        state   <= RESP;
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end
endmodule
